alu_8bit: RTL and testbench

Registered 8-bit arithmetic/logic unit with carry, zero and negative status flags. It sits in the datapath execute stage and performs one of eight operations, selected by a 3-bit opcode, on two 8-bit operands. Operands are sampled on a valid strobe, and the result and flags are registered with one-cycle latency.

---
 rtl/alu_8bit.sv | 138 +++++++++++++
 tb/tb_alu_8bit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_8bit.sv
// Registered 8-bit ALU with carry/zero/negative flags and one-cycle latency.
// Define ALU_OVF_EN to add a registered signed-overflow flag output (Overflow).
module alu_8bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [2:0] Opcode,
  input  logic       Carry_in,
  output logic [7:0] Result,
  output logic       Carry_out,
  output logic       Zero,
  output logic       Negative,
  output logic       out_valid
`ifdef ALU_OVF_EN
  ,
  output logic       Overflow
`endif
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpNot = 3'b101;
  localparam logic [2:0] OpShl = 3'b110;
  localparam logic [2:0] OpShr = 3'b111;

  logic [8:0] add_w;
  logic [8:0] sub_w;
  logic [7:0] alu_res;
  logic       alu_c;

  logic [7:0] result_q, result_d;
  logic       carry_q, carry_d;
  logic       zero_q, zero_d;
  logic       neg_q, neg_d;
  logic       valid_q, valid_d;

  assign add_w = {1'b0, A} + {1'b0, B} + {8'h00, Carry_in};
  // Bit 8 of the 9-bit difference is set exactly when A < B + Carry_in.
  assign sub_w = {1'b0, A} - {1'b0, B} - {8'h00, Carry_in};

  always_comb begin
    alu_res = 8'h00;
    alu_c   = 1'b0;
    case (Opcode)
      OpAdd: {alu_c, alu_res} = add_w;
      OpSub: {alu_c, alu_res} = sub_w;
      OpAnd: alu_res = A & B;
      OpOr:  alu_res = A | B;
      OpXor: alu_res = A ^ B;
      OpNot: alu_res = ~A;
      OpShl: begin
        alu_res = {A[6:0], 1'b0};
        alu_c   = A[7];
      end
      OpShr: begin
        alu_res = {1'b0, A[7:1]};
        alu_c   = A[0];
      end
      default: begin
        alu_res = 8'h00;
        alu_c   = 1'b0;
      end
    endcase
  end

  always_comb begin
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    valid_d  = in_valid;
    if (in_valid) begin
      result_d = alu_res;
      carry_d  = alu_c;
      zero_d   = (alu_res == 8'h00);
      neg_d    = alu_res[7];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 8'h00;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      valid_q  <= valid_d;
    end
  end

  assign Result    = result_q;
  assign Carry_out = carry_q;
  assign Zero      = zero_q;
  assign Negative  = neg_q;
  assign out_valid = valid_q;

`ifdef ALU_OVF_EN
  logic alu_ovf;
  logic ovf_q, ovf_d;

  always_comb begin
    alu_ovf = 1'b0;
    if (Opcode == OpAdd) begin
      alu_ovf = (A[7] == B[7]) && (alu_res[7] != A[7]);
    end else if (Opcode == OpSub) begin
      alu_ovf = (A[7] != B[7]) && (alu_res[7] != A[7]);
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) begin
      ovf_d = alu_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign Overflow = ovf_q;
`endif

endmodule

// File: tb/tb_alu_8bit.sv
// Scoreboard bench for alu_8bit: expected {ovf,c,z,n,result} queued at drive time.
module tb_alu_8bit;

  typedef struct packed {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        cin;
    logic [11:0] exp;  // {ovf, carry, zero, neg, result[7:0]}
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] Opcode;
  logic       Carry_in;
  logic [7:0] Result;
  logic       Carry_out;
  logic       Zero;
  logic       Negative;
  logic       out_valid;
`ifdef ALU_OVF_EN
  logic       Overflow;
`endif

  logic [11:0] sb[$];
  int vectors = 0;
  int errs    = 0;

  alu_8bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .Opcode    (Opcode),
    .Carry_in  (Carry_in),
    .Result    (Result),
    .Carry_out (Carry_out),
    .Zero      (Zero),
    .Negative  (Negative),
    .out_valid (out_valid)
`ifdef ALU_OVF_EN
    ,
    .Overflow  (Overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] model(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic cin);
    logic [7:0] r;
    logic       c;
    logic       v;
    int         s;
    r = 8'h00;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin
        s = int'(a) + int'(b) + int'(cin);
        r = 8'(s);
        c = (s > 255);
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'd1: begin
        s = int'(a) - int'(b) - int'(cin);
        r = 8'(s);
        c = (s < 0);
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin r = {a[6:0], 1'b0}; c = a[7]; end
      default: begin r = {1'b0, a[7:1]}; c = a[0]; end
    endcase
    return {v, c, (r == 8'h00), r[7], r};
  endfunction

  // Drive one op for a single cycle at the negedge and queue its expectation.
  task automatic issue(input vec_t t);
    @(negedge clk);
    Opcode   = t.op;
    A        = t.a;
    B        = t.b;
    Carry_in = t.cin;
    in_valid = 1'b1;
    sb.push_back(t.exp);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    A        = 8'h00;
    B        = 8'h00;
    Opcode   = 3'd0;
    Carry_in = 1'b0;
    #1;
    vectors++;
    if ({out_valid, Carry_out, Zero, Negative, Result} !== 12'h000) begin
      errs++;
      $display("FAIL reset: got ov=%b c=%b z=%b n=%b r=%h, want all 0",
               out_valid, Carry_out, Zero, Negative, Result);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    vec_t t[4];
    logic [11:0] e;
    t[0] = '{3'd0, 8'h55, 8'hAA, 1'b0, {4'b0001, 8'hFF}};
    t[1] = '{3'd0, 8'hFF, 8'h01, 1'b0, {4'b0110, 8'h00}};
    t[2] = '{3'd0, 8'hFF, 8'h00, 1'b1, {4'b0110, 8'h00}};
    t[3] = '{3'd0, 8'h7F, 8'h01, 1'b0, {4'b1001, 8'h80}};
    for (int i = 0; i < 4; i++) begin
      issue(t[i]);
      e = sb.pop_front();
      vectors++;
      if (out_valid !== 1'b1 || {Carry_out, Zero, Negative, Result} !== e[10:0]) begin
        errs++;
        $display("FAIL add[%0d]: got ov=%b c=%b z=%b n=%b r=%h, want ov=1 c=%b z=%b n=%b r=%h",
                 i, out_valid, Carry_out, Zero, Negative, Result, e[10], e[9], e[8], e[7:0]);
      end
`ifdef ALU_OVF_EN
      vectors++;
      if (Overflow !== e[11]) begin
        errs++;
        $display("FAIL add_ovf[%0d]: got %b, want %b", i, Overflow, e[11]);
      end
`endif
    end
  endtask

  task automatic test_sub;
    vec_t t[3];
    logic [11:0] e;
    t[0] = '{3'd1, 8'h55, 8'h10, 1'b0, {4'b0000, 8'h45}};
    t[1] = '{3'd1, 8'h10, 8'h55, 1'b0, {4'b0101, 8'hBB}};
    t[2] = '{3'd1, 8'h10, 8'h0F, 1'b1, {4'b0010, 8'h00}};
    for (int i = 0; i < 3; i++) begin
      issue(t[i]);
      e = sb.pop_front();
      vectors++;
      if (out_valid !== 1'b1 || {Carry_out, Zero, Negative, Result} !== e[10:0]) begin
        errs++;
        $display("FAIL sub[%0d]: got ov=%b c=%b z=%b n=%b r=%h, want ov=1 c=%b z=%b n=%b r=%h",
                 i, out_valid, Carry_out, Zero, Negative, Result, e[10], e[9], e[8], e[7:0]);
      end
    end
  endtask

  task automatic test_logic;
    vec_t t[4];
    logic [11:0] e;
    // Carry_in set on purpose: logic ops must still report carry 0.
    t[0] = '{3'd2, 8'h55, 8'h0F, 1'b1, {4'b0000, 8'h05}};
    t[1] = '{3'd3, 8'h55, 8'h0F, 1'b1, {4'b0000, 8'h5F}};
    t[2] = '{3'd4, 8'h55, 8'hFF, 1'b1, {4'b0001, 8'hAA}};
    t[3] = '{3'd5, 8'h55, 8'h0F, 1'b1, {4'b0001, 8'hAA}};
    for (int i = 0; i < 4; i++) begin
      issue(t[i]);
      e = sb.pop_front();
      vectors++;
      if (out_valid !== 1'b1 || {Carry_out, Zero, Negative, Result} !== e[10:0]) begin
        errs++;
        $display("FAIL logic[%0d]: got ov=%b c=%b z=%b n=%b r=%h, want ov=1 c=%b z=%b n=%b r=%h",
                 i, out_valid, Carry_out, Zero, Negative, Result, e[10], e[9], e[8], e[7:0]);
      end
    end
  endtask

  task automatic test_shift;
    vec_t t[3];
    logic [11:0] e;
    t[0] = '{3'd6, 8'hAA, 8'hFF, 1'b1, {4'b0100, 8'h54}};
    t[1] = '{3'd7, 8'hAA, 8'hFF, 1'b1, {4'b0000, 8'h55}};
    t[2] = '{3'd7, 8'h01, 8'hFF, 1'b0, {4'b0110, 8'h00}};
    for (int i = 0; i < 3; i++) begin
      issue(t[i]);
      e = sb.pop_front();
      vectors++;
      if (out_valid !== 1'b1 || {Carry_out, Zero, Negative, Result} !== e[10:0]) begin
        errs++;
        $display("FAIL shift[%0d]: got ov=%b c=%b z=%b n=%b r=%h, want ov=1 c=%b z=%b n=%b r=%h",
                 i, out_valid, Carry_out, Zero, Negative, Result, e[10], e[9], e[8], e[7:0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    vec_t t[3];
    logic [11:0] e;
    t[0] = '{3'd0, 8'h01, 8'h02, 1'b0, {4'b0000, 8'h03}};
    t[1] = '{3'd1, 8'h05, 8'h01, 1'b0, {4'b0000, 8'h04}};
    t[2] = '{3'd4, 8'hF0, 8'h0F, 1'b0, {4'b0001, 8'hFF}};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sb.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || {Carry_out, Zero, Negative, Result} !== e[10:0]) begin
          errs++;
          $display("FAIL b2b[%0d]: got ov=%b c=%b z=%b n=%b r=%h, want ov=1 c=%b z=%b n=%b r=%h",
                   i - 1, out_valid, Carry_out, Zero, Negative, Result,
                   e[10], e[9], e[8], e[7:0]);
        end
      end
      if (i < 3) begin
        Opcode   = t[i].op;
        A        = t[i].a;
        B        = t[i].b;
        Carry_in = t[i].cin;
        in_valid = 1'b1;
        sb.push_back(t[i].exp);
      end else begin
        in_valid = 1'b0;
      end
    end
    // Idle cycles with changing inputs: outputs hold the third op, out_valid low.
    for (int i = 0; i < 2; i++) begin
      Opcode = 3'd0;
      A      = 8'h12 + 8'(i);
      B      = 8'h34;
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || {Carry_out, Zero, Negative, Result} !== 11'b001_1111_1111) begin
        errs++;
        $display("FAIL hold[%0d]: got ov=%b c=%b z=%b n=%b r=%h, want ov=0 c=0 z=0 n=1 r=ff",
                 i, out_valid, Carry_out, Zero, Negative, Result);
      end
    end
  endtask

  task automatic test_random;
    vec_t t;
    logic [11:0] e;
    for (int i = 0; i < 40; i++) begin
      t.op  = 3'($urandom_range(0, 7));
      t.a   = 8'($urandom);
      t.b   = 8'($urandom);
      t.cin = 1'($urandom);
      t.exp = model(t.op, t.a, t.b, t.cin);
      issue(t);
      e = sb.pop_front();
      vectors++;
      if (out_valid !== 1'b1 || {Carry_out, Zero, Negative, Result} !== e[10:0]) begin
        errs++;
        $display("FAIL rand[%0d] op=%0d a=%h b=%h ci=%b: got c=%b z=%b n=%b r=%h, want c=%b z=%b n=%b r=%h",
                 i, t.op, t.a, t.b, t.cin, Carry_out, Zero, Negative, Result,
                 e[10], e[9], e[8], e[7:0]);
      end
`ifdef ALU_OVF_EN
      vectors++;
      if (Overflow !== e[11]) begin
        errs++;
        $display("FAIL rand_ovf[%0d]: got %b, want %b", i, Overflow, e[11]);
      end
`endif
    end
  endtask

  task automatic test_reset_midstream;
    vec_t t;
    logic [11:0] e;
    t = '{3'd0, 8'hFF, 8'h00, 1'b0, {4'b0001, 8'hFF}};
    issue(t);
    e = sb.pop_front();
    vectors++;
    if (out_valid !== 1'b1 || {Carry_out, Zero, Negative, Result} !== e[10:0]) begin
      errs++;
      $display("FAIL pre_reset: got ov=%b r=%h, want ov=1 r=%h", out_valid, Result, e[7:0]);
    end
    // Put an op in flight, then reset between edges.
    Opcode   = 3'd0;
    A        = 8'h01;
    B        = 8'h01;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, Carry_out, Zero, Negative, Result} !== 12'h000) begin
      errs++;
      $display("FAIL async_reset: got ov=%b c=%b z=%b n=%b r=%h, want all 0",
               out_valid, Carry_out, Zero, Negative, Result);
    end
`ifdef ALU_OVF_EN
    vectors++;
    if (Overflow !== 1'b0) begin
      errs++;
      $display("FAIL async_reset_ovf: got %b, want 0", Overflow);
    end
`endif
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({out_valid, Carry_out, Zero, Negative, Result} !== 12'h000) begin
      errs++;
      $display("FAIL post_reset: got ov=%b r=%h, want ov=0 r=00", out_valid, Result);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_shift();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
